// File: rtl/itch_msg_parser_if.sv
// Bus between the ITCH byte-stream source and the message parser.
// The master drives the byte stream; the slave (parser) returns decoded Add Order fields and message events.
interface itch_msg_parser_if;
    logic [7:0]  dataIn;
    logic        dataValidIn;
    logic        packetLostIn;
    logic        addValidOut;
    logic [15:0] addLocateOut;
    logic [63:0] addOrderRefOut;
    logic        addBuyOut;
    logic [31:0] addSharesOut;
    logic [63:0] addStockOut;
    logic [31:0] addPriceOut;
    logic        msgDoneOut;
    logic [7:0]  msgTypeOut;
    logic        errOut;

    modport master (
        output dataIn, dataValidIn, packetLostIn,
        input  addValidOut, addLocateOut, addOrderRefOut, addBuyOut, addSharesOut,
        input  addStockOut, addPriceOut, msgDoneOut, msgTypeOut, errOut
    );

    modport slave (
        input  dataIn, dataValidIn, packetLostIn,
        output addValidOut, addLocateOut, addOrderRefOut, addBuyOut, addSharesOut,
        output addStockOut, addPriceOut, msgDoneOut, msgTypeOut, errOut
    );
endinterface

// File: rtl/itch_msg_parser.sv
// Splits a MoldUDP64 block stream (2-byte length + message) and decodes ITCH Add Order ('A') messages.
// state  | meaning
// LEN_HI | waiting for length high byte
// LEN_LO | waiting for length low byte
// BODY   | consuming message bytes idx 0..len-1
module itch_msg_parser #(
    parameter logic [15:0] MAX_MSG_LEN = 16'd64
) (
    input logic clkIn,
    input logic rstIn,
    itch_msg_parser_if.slave bus
);
    typedef enum logic [1:0] {LEN_HI, LEN_LO, BODY} state_t;

    state_t      state_q;
    logic [15:0] len_q;
    logic [15:0] idx_q;

    // Staging registers collect fields while the message streams in
    logic [7:0]  type_q,   type_d;
    logic [15:0] loc_q,    loc_d;
    logic [63:0] ref_q,    ref_d;
    logic [7:0]  side_q,   side_d;
    logic [31:0] shares_q, shares_d;
    logic [63:0] stock_q,  stock_d;
    logic [31:0] price_q,  price_d;

    logic        add_valid_q;
    logic [15:0] add_locate_q;
    logic [63:0] add_ref_q;
    logic        add_buy_q;
    logic [31:0] add_shares_q;
    logic [63:0] add_stock_q;
    logic [31:0] add_price_q;
    logic        msg_done_q;
    logic [7:0]  msg_type_q;
    logic        err_q;

    logic        accept;
    logic        last_byte;
    logic        over_len;
    logic        side_ok;
    logic [15:0] len_lo_d;

    assign accept    = (state_q == BODY) && bus.dataValidIn && !bus.packetLostIn;
    assign last_byte = (idx_q == len_q - 16'd1);
    assign over_len  = (len_q > MAX_MSG_LEN);
    assign side_ok   = (side_d == 8'h42) || (side_d == 8'h53);
    assign len_lo_d  = {len_q[15:8], bus.dataIn};

    // Next-state staging includes the byte arriving this cycle, so the final byte can be a field byte
    always_comb begin
        type_d   = type_q;
        loc_d    = loc_q;
        ref_d    = ref_q;
        side_d   = side_q;
        shares_d = shares_q;
        stock_d  = stock_q;
        price_d  = price_q;
        if (accept) begin
            if (idx_q == 16'd0)                        type_d   = bus.dataIn;
            if (idx_q >= 16'd1  && idx_q <= 16'd2)     loc_d    = {loc_q[7:0], bus.dataIn};
            if (idx_q >= 16'd11 && idx_q <= 16'd18)    ref_d    = {ref_q[55:0], bus.dataIn};
            if (idx_q == 16'd19)                       side_d   = bus.dataIn;
            if (idx_q >= 16'd20 && idx_q <= 16'd23)    shares_d = {shares_q[23:0], bus.dataIn};
            if (idx_q >= 16'd24 && idx_q <= 16'd31)    stock_d  = {stock_q[55:0], bus.dataIn};
            if (idx_q >= 16'd32 && idx_q <= 16'd35)    price_d  = {price_q[23:0], bus.dataIn};
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state_q      <= LEN_HI;
            len_q        <= '0;
            idx_q        <= '0;
            type_q       <= '0;
            loc_q        <= '0;
            ref_q        <= '0;
            side_q       <= '0;
            shares_q     <= '0;
            stock_q      <= '0;
            price_q      <= '0;
            add_valid_q  <= 1'b0;
            add_locate_q <= '0;
            add_ref_q    <= '0;
            add_buy_q    <= 1'b0;
            add_shares_q <= '0;
            add_stock_q  <= '0;
            add_price_q  <= '0;
            msg_done_q   <= 1'b0;
            msg_type_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            add_valid_q <= 1'b0;
            msg_done_q  <= 1'b0;
            err_q       <= 1'b0;
            type_q      <= type_d;
            loc_q       <= loc_d;
            ref_q       <= ref_d;
            side_q      <= side_d;
            shares_q    <= shares_d;
            stock_q     <= stock_d;
            price_q     <= price_d;
            if (bus.packetLostIn) begin
                state_q <= LEN_HI;
                idx_q   <= '0;
            end else if (bus.dataValidIn) begin
                case (state_q)
                    LEN_HI: begin
                        len_q   <= {bus.dataIn, len_q[7:0]};
                        state_q <= LEN_LO;
                    end
                    LEN_LO: begin
                        len_q <= len_lo_d;
                        idx_q <= '0;
                        if (len_lo_d == 16'd0) begin
                            err_q   <= 1'b1;
                            state_q <= LEN_HI;
                        end else begin
                            state_q <= BODY;
                        end
                    end
                    BODY: begin
                        if (idx_q != 16'hFFFF) idx_q <= idx_q + 16'd1;
                        if (last_byte) begin
                            state_q    <= LEN_HI;
                            msg_done_q <= 1'b1;
                            msg_type_q <= type_d;
                            if (over_len) begin
                                err_q <= 1'b1;
                            end else if (type_d == 8'h41) begin
                                if (len_q >= 16'd36 && side_ok) begin
                                    add_valid_q  <= 1'b1;
                                    add_locate_q <= loc_d;
                                    add_ref_q    <= ref_d;
                                    add_buy_q    <= (side_d == 8'h42);
                                    add_shares_q <= shares_d;
                                    add_stock_q  <= stock_d;
                                    add_price_q  <= price_d;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state_q <= LEN_HI;
                endcase
            end
        end
    end

    assign bus.addValidOut    = add_valid_q;
    assign bus.addLocateOut   = add_locate_q;
    assign bus.addOrderRefOut = add_ref_q;
    assign bus.addBuyOut      = add_buy_q;
    assign bus.addSharesOut   = add_shares_q;
    assign bus.addStockOut    = add_stock_q;
    assign bus.addPriceOut    = add_price_q;
    assign bus.msgDoneOut     = msg_done_q;
    assign bus.msgTypeOut     = msg_type_q;
    assign bus.errOut         = err_q;
endmodule

// File: tb/tb_itch_msg_parser.sv
// Directed bench for itch_msg_parser: builds MoldUDP64 blocks byte by byte and checks decoded events.
module tb_itch_msg_parser;
    logic clkIn;
    logic rstIn;
    itch_msg_parser_if bus();

    itch_msg_parser #(.MAX_MSG_LEN(16'd64)) dut (
        .clkIn(clkIn),
        .rstIn(rstIn),
        .bus  (bus)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    localparam logic [15:0] EXP_LOC   = 16'h0001;
    localparam logic [63:0] EXP_REF   = 64'h0123456789ABCDEF;
    localparam logic [31:0] EXP_SHR   = 32'd100;
    localparam logic [63:0] EXP_STOCK = 64'h4141504C20202020;
    localparam logic [31:0] EXP_PRICE = 32'd1500000;

    int tests = 0;
    int fails = 0;
    int n_add = 0, n_done = 0, n_err = 0, n_orphan = 0;
    logic [7:0] types[$];
    logic [7:0] q[$];
    int b_add, b_done, b_err, b_types;

    always @(negedge clkIn) begin
        if (bus.addValidOut) n_add++;
        if (bus.msgDoneOut) begin
            n_done++;
            types.push_back(bus.msgTypeOut);
        end
        if (bus.errOut) n_err++;
        if (bus.addValidOut && !bus.msgDoneOut) n_orphan++;
    end

    function automatic logic [7:0] a_byte(input int i, input logic [7:0] side);
        logic [63:0] r;
        logic [63:0] st;
        logic [31:0] sh;
        logic [31:0] pr;
        logic [7:0]  iv;
        r = EXP_REF; st = EXP_STOCK; sh = EXP_SHR; pr = EXP_PRICE;
        iv = 8'(i);
        if (i == 0) return 8'h41;
        if (i == 1) return 8'h00;
        if (i == 2) return 8'h01;
        if (i >= 3 && i <= 10) return 8'hE0 + iv;
        if (i >= 11 && i <= 18) return r[8*(18-i) +: 8];
        if (i == 19) return side;
        if (i >= 20 && i <= 23) return sh[8*(23-i) +: 8];
        if (i >= 24 && i <= 31) return st[8*(31-i) +: 8];
        if (i >= 32 && i <= 35) return pr[8*(35-i) +: 8];
        return 8'hCC;
    endfunction

    task automatic push_len(input logic [15:0] len);
        q.push_back(len[15:8]);
        q.push_back(len[7:0]);
    endtask

    task automatic push_a(input logic [15:0] len, input logic [7:0] side);
        push_len(len);
        for (int i = 0; i < int'(len); i++) q.push_back(a_byte(i, side));
    endtask

    task automatic push_s(input logic [15:0] len);
        push_len(len);
        q.push_back(8'h53);
        for (int i = 1; i < int'(len); i++) q.push_back(8'h10 + 8'(i));
    endtask

    // Sends the first n queued bytes (all if n < 0), optionally with random idle gaps, then empties the queue
    task automatic send_q(input bit gaps, input int n);
        int lim;
        lim = (n < 0) ? q.size() : n;
        for (int k = 0; k < lim; k++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                @(negedge clkIn);
                bus.dataValidIn = 1'b0;
            end
            @(negedge clkIn);
            bus.dataIn      = q[k];
            bus.dataValidIn = 1'b1;
        end
        @(negedge clkIn);
        bus.dataValidIn = 1'b0;
        q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clkIn);
    endtask

    task automatic mark;
        b_add = n_add; b_done = n_done; b_err = n_err; b_types = types.size();
    endtask

    task automatic check_counts(input string name, input int e_add, input int e_done, input int e_err);
        tests++;
        if (n_add - b_add !== e_add) begin
            fails++; $display("FAIL %s add pulses: got %0d want %0d", name, n_add - b_add, e_add);
        end
        tests++;
        if (n_done - b_done !== e_done) begin
            fails++; $display("FAIL %s done pulses: got %0d want %0d", name, n_done - b_done, e_done);
        end
        tests++;
        if (n_err - b_err !== e_err) begin
            fails++; $display("FAIL %s err pulses: got %0d want %0d", name, n_err - b_err, e_err);
        end
    endtask

    task automatic check_fields(input string name, input logic e_buy);
        tests++;
        if (bus.addLocateOut !== EXP_LOC) begin
            fails++; $display("FAIL %s locate: got %h want %h", name, bus.addLocateOut, EXP_LOC);
        end
        tests++;
        if (bus.addOrderRefOut !== EXP_REF) begin
            fails++; $display("FAIL %s orderRef: got %h want %h", name, bus.addOrderRefOut, EXP_REF);
        end
        tests++;
        if (bus.addBuyOut !== e_buy) begin
            fails++; $display("FAIL %s buy: got %b want %b", name, bus.addBuyOut, e_buy);
        end
        tests++;
        if (bus.addSharesOut !== EXP_SHR) begin
            fails++; $display("FAIL %s shares: got %0d want %0d", name, bus.addSharesOut, EXP_SHR);
        end
        tests++;
        if (bus.addStockOut !== EXP_STOCK) begin
            fails++; $display("FAIL %s stock: got %h want %h", name, bus.addStockOut, EXP_STOCK);
        end
        tests++;
        if (bus.addPriceOut !== EXP_PRICE) begin
            fails++; $display("FAIL %s price: got %0d want %0d", name, bus.addPriceOut, EXP_PRICE);
        end
    endtask

    task automatic check_type(input string name, input int k, input logic [7:0] e_type);
        tests++;
        if (types.size() <= b_types + k) begin
            fails++; $display("FAIL %s msgType[%0d]: got none want %h", name, k, e_type);
        end else if (types[b_types + k] !== e_type) begin
            fails++; $display("FAIL %s msgType[%0d]: got %h want %h", name, k, types[b_types + k], e_type);
        end
    endtask

    task automatic test_reset;
        rstIn = 1'b1;
        bus.dataIn = 8'h00; bus.dataValidIn = 1'b0; bus.packetLostIn = 1'b0;
        idle(3);
        tests++;
        if ({bus.addValidOut, bus.msgDoneOut, bus.errOut} !== 3'b000) begin
            fails++; $display("FAIL reset pulses: got %b want 000", {bus.addValidOut, bus.msgDoneOut, bus.errOut});
        end
        tests++;
        if ({bus.addLocateOut, bus.addOrderRefOut, bus.msgTypeOut} !== '0) begin
            fails++; $display("FAIL reset fields: got %h want 0", {bus.addLocateOut, bus.addOrderRefOut, bus.msgTypeOut});
        end
        rstIn = 1'b0;
        idle(2);
    endtask

    task automatic test_single_add;
        mark();
        push_a(16'h0024, 8'h42);
        send_q(1'b0, -1);
        idle(3);
        check_counts("single", 1, 1, 0);
        check_type("single", 0, 8'h41);
        check_fields("single", 1'b1);
    endtask

    task automatic test_gaps;
        mark();
        push_a(16'h0024, 8'h42);
        send_q(1'b1, -1);
        idle(3);
        check_counts("gaps", 1, 1, 0);
        check_type("gaps", 0, 8'h41);
        check_fields("gaps", 1'b1);
    endtask

    task automatic test_back_to_back;
        mark();
        push_s(16'd12);
        push_a(16'h0024, 8'h53);
        send_q(1'b0, -1);
        idle(3);
        check_counts("b2b", 1, 2, 0);
        check_type("b2b", 0, 8'h53);
        check_type("b2b", 1, 8'h41);
        check_fields("b2b", 1'b0);
    endtask

    task automatic test_short_len;
        mark();
        push_a(16'h0014, 8'h42);
        send_q(1'b0, -1);
        idle(3);
        check_counts("short", 0, 1, 1);
        tests++;
        if (bus.addBuyOut !== 1'b0) begin
            fails++; $display("FAIL short held buy: got %b want 0", bus.addBuyOut);
        end
        mark();
        push_a(16'h0024, 8'h42);
        send_q(1'b0, -1);
        idle(3);
        check_counts("after_short", 1, 1, 0);
        check_fields("after_short", 1'b1);
    endtask

    task automatic test_bad_side;
        mark();
        push_a(16'h0024, 8'h58);
        send_q(1'b0, -1);
        idle(3);
        check_counts("bad_side", 0, 1, 1);
    endtask

    task automatic test_over_len;
        mark();
        push_a(16'h0050, 8'h42);
        push_a(16'h0024, 8'h53);
        send_q(1'b0, -1);
        idle(3);
        check_counts("over_len", 1, 2, 1);
        check_type("over_len", 1, 8'h41);
        check_fields("over_len", 1'b0);
    endtask

    task automatic test_len_zero;
        mark();
        push_len(16'h0000);
        push_a(16'h0024, 8'h42);
        send_q(1'b0, -1);
        idle(3);
        check_counts("len_zero", 1, 1, 1);
        check_fields("len_zero", 1'b1);
    endtask

    task automatic test_packet_lost;
        mark();
        push_a(16'h0024, 8'h42);
        send_q(1'b0, 22);
        @(negedge clkIn);
        bus.packetLostIn = 1'b1; bus.dataValidIn = 1'b1; bus.dataIn = 8'h00;
        @(negedge clkIn);
        bus.packetLostIn = 1'b0; bus.dataValidIn = 1'b0;
        idle(2);
        check_counts("lost_partial", 0, 0, 0);
        push_a(16'h0024, 8'h53);
        send_q(1'b0, -1);
        idle(3);
        check_counts("lost_then_new", 1, 1, 0);
        check_fields("lost_then_new", 1'b0);
    endtask

    task automatic test_reset_mid;
        mark();
        push_a(16'h0024, 8'h42);
        send_q(1'b0, 12);
        @(negedge clkIn);
        #1 rstIn = 1'b1;
        #1;
        tests++;
        if ({bus.addLocateOut, bus.addPriceOut} !== '0) begin
            fails++; $display("FAIL rst_mid fields: got %h want 0", {bus.addLocateOut, bus.addPriceOut});
        end
        @(negedge clkIn);
        rstIn = 1'b0;
        idle(1);
        mark();
        push_a(16'h0024, 8'h42);
        send_q(1'b0, -1);
        idle(3);
        check_counts("rst_then_new", 1, 1, 0);
        check_fields("rst_then_new", 1'b1);
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_gaps();
        test_back_to_back();
        test_short_len();
        test_bad_side();
        test_over_len();
        test_len_zero();
        test_packet_lost();
        test_reset_mid();
        tests++;
        if (n_orphan !== 0) begin
            fails++; $display("FAIL add_without_done: got %0d want 0", n_orphan);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/itch_msg_parser.md
ITCH_MSG_PARSER -- requirements
Module: itch_msg_parser

Interface
REQ-001 SHALL have parameter MAX_MSG_LEN, default 16'd64, maximum accepted MoldUDP64 message length in bytes.
REQ-002 SHALL have port clkIn  input  1  250MHz processing clock, same domain as the header parser.
REQ-003 SHALL have port rstIn  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port dataIn  input  8  ITCH byte stream: concatenated MoldUDP64 message blocks (2-byte length + message).
REQ-005 SHALL have port dataValidIn  input  1  dataIn qualifier; gaps allowed anywhere.
REQ-006 SHALL have port packetLostIn  input  1  abort; discard any partial message.
REQ-007 SHALL have port addValidOut  output  1  one-cycle pulse: Add Order ('A') fields valid.
REQ-008 SHALL have port addLocateOut  output  16  stock locate.
REQ-009 SHALL have port addOrderRefOut  output  64  order reference number.
REQ-010 SHALL have port addBuyOut  output  1  1 = 'B', 0 = 'S'.
REQ-011 SHALL have port addSharesOut  output  32  share count.
REQ-012 SHALL have port addStockOut  output  64  8 ASCII stock bytes, first byte in [63:56].
REQ-013 SHALL have port addPriceOut  output  32  price, 4 implied decimals.
REQ-014 SHALL have port msgDoneOut  output  1  one-cycle pulse at end of any message.
REQ-015 SHALL have port msgTypeOut  output  8  type byte of the message ending at msgDoneOut.
REQ-016 SHALL have port errOut  output  1  one-cycle pulse: length or format error.

Function
REQ-017 SHALL use FSM states LEN_HI, LEN_LO, BODY; bytes advance state only when dataValidIn=1.
REQ-018 SHALL, in LEN_HI, latch dataIn as len[15:8] -> LEN_LO; in LEN_LO latch len[7:0] and clear byte counter idx -> BODY.
REQ-019 SHALL, when len==0 at LEN_LO, pulse errOut next cycle and return to LEN_HI.
REQ-020 SHALL, in BODY, accept bytes at idx 0..len-1; idx is 16-bit, increments per valid byte, never wraps.
REQ-021 SHALL capture big-endian fields of type 'A' (0x41) at offsets: type 0, locate 1-2, orderRef 11-18, side 19, shares 20-23, stock 24-31, price 32-35; bytes 3-10 and any beyond 35 ignored.
REQ-022 SHALL, on the byte where idx==len-1, return to LEN_HI and, on the next cycle, pulse msgDoneOut with msgTypeOut = byte 0.
REQ-023 SHALL pulse addValidOut on the same cycle as msgDoneOut only if type=='A', len>=36, len<=MAX_MSG_LEN and side byte is 0x42 or 0x53.
REQ-024 SHALL pulse errOut instead of addValidOut when type=='A' and len<36 or side byte invalid.
REQ-025 SHALL, when len>MAX_MSG_LEN, consume and discard all len bytes, then pulse errOut and msgDoneOut; no addValidOut.
REQ-026 SHALL hold add* field outputs stable between addValidOut pulses; non-'A' messages SHALL NOT disturb them.
REQ-027 SHALL, on packetLostIn=1 in any state, return to LEN_HI next cycle, clear idx, suppress msgDoneOut/addValidOut for the partial message; a byte valid on that cycle is dropped.
REQ-028 SHALL accept a new length byte on the cycle after the final body byte with no bubble (back-to-back messages at full rate).

Reset
REQ-029 SHALL, while rstIn=1, force state LEN_HI, idx=0, len=0 and all outputs to 0, asynchronously.
REQ-030 SHALL resume parsing on the first valid byte after rstIn deasserts, treating it as len[15:8].

Verification
REQ-031 SHALL cover: one 'A' message, len 0x0024, locate 0x0001, orderRef 0x0123456789ABCDEF, side 'B', shares 100, stock "AAPL    ", price 1500000 -> one addValidOut, fields exact, addBuyOut=1, msgTypeOut=0x41.
REQ-032 SHALL cover: same message with random dataValidIn gaps (50% duty) -> identical outputs, single pulse.
REQ-033 SHALL cover: 'S' (len 12) then 'A' back-to-back, no gaps -> msgDoneOut type 0x53, then addValidOut; no errOut.
REQ-034 SHALL cover: 'A' with len 0x0014 -> errOut pulse, no addValidOut, next message parsed correctly.
REQ-035 SHALL cover: len 0x0050 (>64) -> 80 bytes discarded, errOut+msgDoneOut once, stream re-aligned.
REQ-036 SHALL cover: packetLostIn at idx 20 of an 'A' message, then fresh 'A' -> no output for first, correct addValidOut for second; rstIn mid-message likewise.
